// File: rtl/la_capture_engine_pkg.sv
// Shared encodings and defaults for the logic-analyzer capture engine.
// Optional build macro used elsewhere in the slice: PROBE_SYNC_EN.
package la_capture_engine_pkg;

  localparam int LA_DEFAULT_DEPTH    = 256;
  localparam int LA_DEFAULT_CHANNELS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } la_state_t;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'b00,
    TRIG_RISING    = 2'b01,
    TRIG_FALLING   = 2'b10,
    TRIG_LEVEL     = 2'b11
  } la_trig_mode_t;

  // Status flags {busy, triggered, done} presented while in a given state.
  function automatic logic [2:0] state_flags(input la_state_t st);
    case (st)
      ST_PRE, ST_WAIT: state_flags = 3'b100;
      ST_POST:         state_flags = 3'b110;
      ST_DONE:         state_flags = 3'b011;
      default:         state_flags = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/la_capture_engine_trigger.sv
// Combinational trigger decision for the capture engine (la_trigger_detector).
// Evaluates the current sample against the previous one on the watched channel.
module la_trigger_detector
  import la_capture_engine_pkg::*;
#(
  parameter int CHANNEL_COUNT = LA_DEFAULT_CHANNELS,
  parameter int CW            = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic [CHANNEL_COUNT-1:0] sample_i,
  input  logic [CHANNEL_COUNT-1:0] prev_i,
  input  logic                     prev_valid_i,
  input  la_trig_mode_t            mode_i,
  input  logic [CW-1:0]            chan_i,
  output logic                     fire_o
);

  logic cur_s;
  logic prv_s;

  // Select the watched channel; out-of-range channels read as 0.
  always_comb begin
    cur_s = 1'b0;
    prv_s = 1'b0;
    if (32'(chan_i) < CHANNEL_COUNT) begin
      cur_s = sample_i[chan_i];
      prv_s = prev_i[chan_i];
    end else begin
      cur_s = 1'b0;
      prv_s = 1'b0;
    end
  end

  // Fire decision for each trigger type.
  always_comb begin
    fire_o = 1'b0;
    case (mode_i)
      TRIG_IMMEDIATE: fire_o = 1'b1;
      TRIG_RISING:    fire_o = prev_valid_i & ~prv_s & cur_s;
      TRIG_FALLING:   fire_o = prev_valid_i & prv_s & ~cur_s;
      TRIG_LEVEL:     fire_o = cur_s;
      default:        fire_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/la_capture_engine.sv
// Logic-analyzer acquisition core: prescaled sampling into a circular memory,
// trigger-aligned window freeze and registered read. Optional macro: PROBE_SYNC_EN.
module la_capture_engine
  import la_capture_engine_pkg::*;
#(
  parameter int CHANNEL_COUNT  = LA_DEFAULT_CHANNELS,
  parameter int DEPTH          = LA_DEFAULT_DEPTH,
  parameter int PRESCALE_WIDTH = 16,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNEL_COUNT-1:0]  probe,
  input  logic [CHANNEL_COUNT-1:0]  chan_enable,
  input  logic                      arm,
  input  logic [1:0]                trig_mode,
  input  logic [CW-1:0]             trig_chan,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [AW-1:0]             pretrig,
  input  logic [AW-1:0]             rd_addr,
  output logic [CHANNEL_COUNT-1:0]  rd_data,
  output logic                      busy,
  output logic                      triggered,
  output logic                      done
);

  localparam logic [AW:0]             DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]             CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]           PTR_ONE = AW'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

  logic [CHANNEL_COUNT-1:0] probe_s;

`ifdef PROBE_SYNC_EN
  logic [CHANNEL_COUNT-1:0] sync1_q;
  logic [CHANNEL_COUNT-1:0] sync2_q;

  // Two-flop synchroniser for asynchronous probe pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= probe;
      sync2_q <= sync1_q;
    end
  end
  assign probe_s = sync2_q;
`else
  assign probe_s = probe;
`endif

  la_state_t                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [AW-1:0]             pretrig_q, pretrig_d;
  la_trig_mode_t             mode_q, mode_d;
  logic [CW-1:0]             chan_q, chan_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             start_ptr_q, start_ptr_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic [CHANNEL_COUNT-1:0]  prev_q, prev_d;
  logic                      prev_valid_q, prev_valid_d;
  logic                      busy_q, triggered_q, done_q;
  logic [CHANNEL_COUNT-1:0]  rd_data_q;

  logic [CHANNEL_COUNT-1:0]  sample_s;
  logic                      active_s;
  logic                      tick_s;
  logic                      we_s;
  logic                      fire_s;
  logic [AW:0]               cnt_inc_s;
  logic [AW:0]               post_len_s;

  logic [CHANNEL_COUNT-1:0]  mem_q [DEPTH];

  assign sample_s   = probe_s & chan_enable;
  assign active_s   = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign tick_s     = active_s && (presc_q == prescale_q);
  assign we_s       = tick_s && !arm;
  assign cnt_inc_s  = cnt_q + CNT_ONE;
  // The trigger sample itself is the first of the post-trigger samples.
  assign post_len_s = DEPTH_C - {1'b0, pretrig_q};

  la_trigger_detector #(
    .CHANNEL_COUNT(CHANNEL_COUNT),
    .CW           (CW)
  ) u_trig (
    .sample_i    (sample_s),
    .prev_i      (prev_q),
    .prev_valid_i(prev_valid_q),
    .mode_i      (mode_q),
    .chan_i      (chan_q),
    .fire_o      (fire_s)
  );

  // Next-state logic: arm overrides any tick in the same cycle.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    prescale_d   = prescale_q;
    pretrig_d    = pretrig_q;
    mode_d       = mode_q;
    chan_d       = chan_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (arm) begin
      prescale_d   = prescale;
      pretrig_d    = pretrig;
      mode_d       = la_trig_mode_t'(trig_mode);
      chan_d       = trig_chan;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      presc_d      = '0;
      prev_valid_d = 1'b0;
      if (pretrig == '0) begin
        state_d = ST_WAIT;
      end else begin
        state_d = ST_PRE;
      end
    end else if (tick_s) begin
      presc_d      = '0;
      wr_ptr_d     = wr_ptr_q + PTR_ONE;
      prev_d       = sample_s;
      prev_valid_d = 1'b1;
      case (state_q)
        ST_PRE: begin
          if (cnt_inc_s == {1'b0, pretrig_q}) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_WAIT: begin
          if (fire_s) begin
            start_ptr_d = wr_ptr_q - pretrig_q;
            if (post_len_s == CNT_ONE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_POST: begin
          if (cnt_inc_s == post_len_s) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (active_s) begin
      presc_d = presc_q + PRE_ONE;
    end else begin
      presc_d = '0;
    end
  end

  // Control registers and status flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      prescale_q   <= '0;
      pretrig_q    <= '0;
      mode_q       <= TRIG_IMMEDIATE;
      chan_q       <= '0;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      prescale_q   <= prescale_d;
      pretrig_q    <= pretrig_d;
      mode_q       <= mode_d;
      chan_q       <= chan_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      {busy_q, triggered_q, done_q} <= state_flags(state_d);
    end
  end

  // Sample memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_ptr_q] <= sample_s;
    end
  end

  // Trigger-aligned registered read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[start_ptr_q + rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_la_capture_engine.sv
// Self-checking bench for la_capture_engine: per-capture probe streams are
// checked against a sample-index model of tick timing, trigger and window.
module tb_la_capture_engine;

  localparam int CC    = 8;
  localparam int DEPTH = 256;
  localparam int PW    = 16;
  localparam int MAXC  = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic [CC-1:0] probe;
  logic [CC-1:0] chan_enable;
  logic          arm;
  logic [1:0]    trig_mode;
  logic [2:0]    trig_chan;
  logic [PW-1:0] prescale;
  logic [7:0]    pretrig;
  logic [7:0]    rd_addr;
  logic [CC-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [7:0] probe_seq [MAXC];
  logic [7:0] samp      [MAXC];

  always #5 clk = ~clk;

  la_capture_engine #(
    .CHANNEL_COUNT (CC),
    .DEPTH         (DEPTH),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .probe      (probe),
    .chan_enable(chan_enable),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_chan  (trig_chan),
    .prescale   (prescale),
    .pretrig    (pretrig),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Change configuration inputs after arm; the engine must ignore them.
  task automatic scramble();
    prescale  = PW'($urandom);
    pretrig   = 8'($urandom);
    trig_mode = 2'($urandom);
    trig_chan = 3'($urandom);
  endtask

  // Arm at cycle 0, replay probe_seq, check status timing, then read the window.
  task automatic capture(input string name, input int p, input int pt,
                         input logic [1:0] mode, input int ch, input logic [7:0] en);
    int         jt;
    int         d;
    int         t;
    int         nk;
    logic [7:0] s;
    logic [7:0] pv;
    bit         fire;
    logic [7:0] win [DEPTH];

    // Ticks fall on cycles that are multiples of p+1 after the arm cycle.
    nk = (MAXC - 1) / (p + 1);
    for (int k = 1; k <= nk; k++) samp[k-1] = probe_seq[k*(p+1)] & en;
    jt = -1;
    for (int j = pt; j < nk && jt < 0; j++) begin
      s  = samp[j];
      pv = (j > 0) ? samp[j-1] : 8'h00;
      case (mode)
        2'b00:   fire = 1'b1;
        2'b01:   fire = (j > 0) && !pv[ch] && s[ch];
        2'b10:   fire = (j > 0) && pv[ch] && !s[ch];
        default: fire = s[ch];
      endcase
      if (fire) jt = j;
    end
    if (jt < 0 || (p + 1) * (jt + DEPTH - pt) + 1 >= MAXC) begin
      $display("FAIL %s: stimulus has no trigger within the cycle budget", name);
      $fatal(1, "capture %s cannot complete", name);
    end
    d = (p + 1) * (jt + DEPTH - pt) + 1;
    t = (p + 1) * (jt + 1) + 1;
    for (int i = 0; i < DEPTH; i++) win[i] = samp[jt - pt + i];

    chan_enable = en;
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("%s busy@arm+1", name), 8'(busy), 8'd1);
        check($sformatf("%s trig@arm+1", name), 8'(triggered), 8'd0);
        check($sformatf("%s done@arm+1", name), 8'(done), 8'd0);
      end
      if (c == t - 1 && t - 1 > 1) check($sformatf("%s trig before", name), 8'(triggered), 8'd0);
      if (c == t) check($sformatf("%s trig rise", name), 8'(triggered), 8'd1);
      if (c == d - 1) begin
        check($sformatf("%s done before", name), 8'(done), 8'd0);
        check($sformatf("%s busy before done", name), 8'(busy), 8'd1);
      end
      if (c == d) begin
        check($sformatf("%s done rise", name), 8'(done), 8'd1);
        check($sformatf("%s busy fall", name), 8'(busy), 8'd0);
        check($sformatf("%s trig in done", name), 8'(triggered), 8'd1);
      end
      probe = probe_seq[c];
      if (c == 0) begin
        arm       = 1'b1;
        prescale  = PW'(p);
        pretrig   = 8'(pt);
        trig_mode = mode;
        trig_chan = 3'(ch);
      end else begin
        arm = 1'b0;
        scramble();
      end
    end

    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      probe = 8'($urandom);
      if (i > 0) check($sformatf("%s rd[%0d]", name, i - 1), rd_data, win[i-1]);
      if (i < DEPTH) rd_addr = 8'(i);
    end
    check($sformatf("%s done held", name), 8'(done), 8'd1);
  endtask

  initial begin
    reset       = 1'b0;
    arm         = 1'b0;
    probe       = 8'h00;
    chan_enable = 8'hFF;
    trig_mode   = 2'b00;
    trig_chan   = 3'd0;
    prescale    = '0;
    pretrig     = 8'd0;
    rd_addr     = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 8'(busy), 8'd0);
    check("reset trig", 8'(triggered), 8'd0);
    check("reset done", 8'(done), 8'd0);
    check("reset rd_data", rd_data, 8'd0);
    reset = 1'b1;

    // Immediate trigger with a counting probe
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'(c - 1);
    capture("imm", 0, 0, 2'b00, 0, 8'hFF);

    // Rising edge on channel 3 at the 100th sample, 64 pre-trigger samples
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom & 32'hF7) | ((c >= 100) ? 8'h08 : 8'h00);
    capture("rise", 0, 64, 2'b01, 3, 8'hFF);

    // Falling edge on channel 5 with prescale 3
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom & 32'hDF) | ((c < 200) ? 8'h20 : 8'h00);
    capture("fall", 3, 10, 2'b10, 5, 8'hFF);

    // Channel mask
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'hFF;
    capture("mask", 0, 5, 2'b00, 0, 8'h0F);

    // Maximum pretrig: the trigger sample completes the window
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom);
    capture("pt_max", 0, 255, 2'b00, 0, 8'hFF);

    // Re-arm while waiting for a trigger that never comes
    @(negedge clk);
    probe     = 8'h00;
    arm       = 1'b1;
    prescale  = '0;
    pretrig   = 8'd4;
    trig_mode = 2'b11;
    trig_chan = 3'd2;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      arm = 1'b0;
      if (c == 1 || c == 30) begin
        check($sformatf("wait busy@%0d", c), 8'(busy), 8'd1);
        check($sformatf("wait trig@%0d", c), 8'(triggered), 8'd0);
      end
    end
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom);
    capture("rearm", 1, 20, 2'b11, 2, 8'hFF);

    // Reset asserted during POST
    @(negedge clk);
    arm       = 1'b1;
    prescale  = '0;
    pretrig   = 8'd0;
    trig_mode = 2'b00;
    rd_addr   = 8'd5;
    probe     = 8'h01;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      arm   = 1'b0;
      probe = 8'($urandom) | 8'h01;
    end
    check("post busy", 8'(busy), 8'd1);
    check("post trig", 8'(triggered), 8'd1);
    reset = 1'b0;
    #1;
    check("midreset busy", 8'(busy), 8'd0);
    check("midreset trig", 8'(triggered), 8'd0);
    check("midreset done", 8'(done), 8'd0);
    check("midreset rd_data", rd_data, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom);
    capture("after_reset", 2, 100, 2'b01, int'($urandom_range(0, 7)), 8'hFF);

    // Randomised level-high captures
    for (int n = 0; n < 3; n++) begin
      int         p;
      int         pt;
      int         ch;
      logic [7:0] en;
      p  = int'($urandom_range(0, 2));
      pt = int'($urandom_range(1, 250));
      ch = int'($urandom_range(0, 7));
      en = 8'($urandom) | 8'(1 << ch);
      for (int c = 0; c < MAXC; c++) probe_seq[c] = 8'($urandom);
      capture($sformatf("level%0d", n), p, pt, 2'b11, ch, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
